// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU and its controller.
//   alu_op_e   : 4-bit operation encoding produced by the ALU controller
//   sh_kind_e  : shift direction/fill selector for the serial shifter
//   ALU_OP_W   : width of the operation code
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SRA = 4'b0110,
    ALU_SLL = 4'b0111,
    ALU_SLT = 4'b1000,
    ALU_EQ  = 4'b1001,
    ALU_NE  = 4'b1010,
    ALU_GE  = 4'b1011
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_SRL = 2'b00,
    SH_SRA = 2'b01,
    SH_SLL = 2'b10
  } sh_kind_e;

  function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_SRL) || (op == ALU_SRA) || (op == ALU_SLL);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// alu_serial_shifter: one-bit-per-cycle shifter with down-counter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture data/amount/kind (amount must be non-zero)
//   kind        : shift direction and fill selection
//   data        : value to shift
//   amount      : number of bit positions
//   done        : high during the final shift cycle (counter == 1)
//   next_value  : working register shifted by one more position; equals the
//                 final result while done is high
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  sh_kind_e              kind,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [SHAMT_W-1:0]    amount,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] next_value
);

  logic [DATA_WIDTH-1:0] work;
  logic [SHAMT_W-1:0]    cnt;
  sh_kind_e              kind_q;

  always_comb begin
    next_value = work;
    case (kind_q)
      SH_SRL:  next_value = {1'b0, work[DATA_WIDTH-1:1]};
      SH_SRA:  next_value = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
      SH_SLL:  next_value = {work[DATA_WIDTH-2:0], 1'b0};
      default: next_value = work;
    endcase
  end

  assign done = (cnt == SHAMT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work   <= '0;
      cnt    <= '0;
      kind_q <= SH_SLL;
    end else if (load) begin
      work   <= data;
      cnt    <= amount;
      kind_q <= kind;
    end else if (cnt != '0) begin
      work <= next_value;
      cnt  <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_iterative.sv
// alu_iterative: multi-cycle integer ALU with valid/ready handshake.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake (in_ready high only in IDLE)
//   Operation, SrcA, SrcB: operation code and operands, captured on accept
//   out_valid / out_ready: result handshake (out_valid high in HOLD)
//   Result, Zero         : registered result and Result == 0 flag
// Logic/arithmetic/compare ops and shifts by 0 finish in one cycle; shifts
// by k > 0 run serially in alu_serial_shifter and finish k cycles later.
module alu_iterative
  import alu_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_OP_W-1:0]   Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10
  } state_e;

  state_e                state;
  alu_op_e               op;
  logic [SHAMT_W-1:0]    shamt;
  logic                  shift_req;
  logic                  sh_load;
  sh_kind_e              sh_kind;
  logic                  sh_done;
  logic [DATA_WIDTH-1:0] sh_value;
  logic [DATA_WIDTH-1:0] single_res;

  assign op        = alu_op_e'(Operation);
  assign shamt     = SrcB[SHAMT_W-1:0];
  assign shift_req = is_shift_op(Operation) && (shamt != '0);
  assign sh_load   = (state == IDLE) && in_valid && shift_req;
  assign in_ready  = (state == IDLE);

  always_comb begin
    sh_kind = SH_SLL;
    case (op)
      ALU_SRL: sh_kind = SH_SRL;
      ALU_SRA: sh_kind = SH_SRA;
      default: sh_kind = SH_SLL;
    endcase
  end

  // Single-cycle datapath; shift ops only reach this path with amount 0.
  always_comb begin
    single_res = '0;
    case (op)
      ALU_AND: single_res = SrcA & SrcB;
      ALU_OR:  single_res = SrcA | SrcB;
      ALU_ADD: single_res = SrcA + SrcB;
      ALU_SUB: single_res = SrcA - SrcB;
      ALU_XOR: single_res = SrcA ^ SrcB;
      ALU_SRL, ALU_SRA, ALU_SLL: single_res = SrcA;
      ALU_SLT: single_res[0] = $signed(SrcA) <  $signed(SrcB);
      ALU_EQ:  single_res[0] = (SrcA == SrcB);
      ALU_NE:  single_res[0] = (SrcA != SrcB);
      ALU_GE:  single_res[0] = $signed(SrcA) >= $signed(SrcB);
      default: single_res = '0;
    endcase
  end

  alu_serial_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_W    (SHAMT_W)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (sh_load),
    .kind       (sh_kind),
    .data       (SrcA),
    .amount     (shamt),
    .done       (sh_done),
    .next_value (sh_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      Result    <= '0;
      Zero      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (shift_req) begin
              state <= SHIFT;
            end else begin
              Result    <= single_res;
              Zero      <= (single_res == '0);
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        SHIFT: begin
          if (sh_done) begin
            Result    <= sh_value;
            Zero      <= (sh_value == '0);
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
module tb_alu_iterative;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Zero;

  int n_cmp = 0;
  int n_bad = 0;

  alu_iterative #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Zero      (Zero)
  );

  always #5 clk = ~clk;

  // Reference model: plain arithmetic from the operation table.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sh = b % 32;
    sa = a;
    sb = b;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a - b;
      4'd4:  return a ^ b;
      4'd5:  return a >> sh;
      4'd6:  return sa >>> sh;
      4'd7:  return a << sh;
      4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  return (a == b) ? 32'd1 : 32'd0;
      4'd10: return (a != b) ? 32'd1 : 32'd0;
      4'd11: return (sa >= sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
    if (op >= 4'd5 && op <= 4'd7) return 1 + int'(b % 32);
    return 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request, scrambles inputs after the accept edge, waits for
  // out_valid (bounded), samples the result and consumes it.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin step(); w++; end
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin step(); lat++; end
    if (w >= 50) lat = 999;
    res = Result;
    z = Zero;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Operation = '0; SrcA = '0; SrcB = '0;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (Result !== 32'd0) begin n_bad++; $display("FAIL reset_result got %h want 0", Result); end
    n_cmp++; if (Zero !== 1'b1) begin n_bad++; $display("FAIL reset_zero got %b want 1", Zero); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
    step();
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[$];
    logic [31:0] r;
    logic z;
    int lat;
    v.push_back('{4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1});
    v.push_back('{4'b0011, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1});
    v.push_back('{4'b0011, 32'd9, 32'd9, 32'd0, 1'b1, 1});
    v.push_back('{4'b0110, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 5});
    v.push_back('{4'b0111, 32'd1, 32'd0, 32'd1, 1'b0, 1});
    v.push_back('{4'b0101, 32'hFFFF_FFFF, 32'h21, 32'h7FFF_FFFF, 1'b0, 2});
    v.push_back('{4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1});
    v.push_back('{4'b1011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1});
    v.push_back('{4'b1001, 32'd4, 32'd4, 32'd1, 1'b0, 1});
    v.push_back('{4'b1010, 32'd4, 32'd4, 32'd0, 1'b1, 1});
    v.push_back('{4'b1111, 32'd123, 32'd456, 32'd0, 1'b1, 1});
    v.push_back('{4'b0111, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 32});
    v.push_back('{4'b0110, 32'h7FFF_FFFF, 32'hFFFF_FFDF, 32'd0, 1'b1, 32});
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, r, z, lat);
      n_cmp++; if (r !== v[i].res) begin n_bad++; $display("FAIL dir%0d_result got %h want %h", i, r, v[i].res); end
      n_cmp++; if (z !== v[i].z) begin n_bad++; $display("FAIL dir%0d_zero got %b want %b", i, z, v[i].z); end
      n_cmp++; if (lat != v[i].lat) begin n_bad++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [31:0] a, b, r, exp;
    logic z;
    int lat;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
      exp = ref_result(op, a, b);
      run_op(op, a, b, r, z, lat);
      n_cmp++; if (r !== exp) begin n_bad++; $display("FAIL rnd%0d_result op=%h a=%h b=%h got %h want %h", i, op, a, b, r, exp); end
      n_cmp++; if (z !== (exp == 32'd0)) begin n_bad++; $display("FAIL rnd%0d_zero got %b want %b", i, z, exp == 32'd0); end
      n_cmp++; if (lat != ref_latency(op, b)) begin n_bad++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, ref_latency(op, b)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp, r;
    logic z;
    int lat;
    exp = 32'hF0F0_0F0F ^ 32'hFFFF_0000;
    Operation = 4'b0100; SrcA = 32'hF0F0_0F0F; SrcB = 32'hFFFF_0000; in_valid = 1'b1; out_ready = 1'b0;
    step();
    // a different request stays asserted while the result is held
    Operation = 4'b0010; SrcA = 32'd1; SrcB = 32'd1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp%0d_out_valid got %b want 1", i, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp%0d_in_ready got %b want 0", i, in_ready); end
      n_cmp++; if (Result !== exp) begin n_bad++; $display("FAIL bp%0d_result got %h want %h", i, Result, exp); end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
    run_op(4'b0010, 32'd20, 32'd22, r, z, lat);
    n_cmp++; if (r !== 32'd42) begin n_bad++; $display("FAIL bp_next_result got %h want %h", r, 32'd42); end
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL bp_next_latency got %0d want 1", lat); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [9];
    logic [3:0] op;
    logic [31:0] a, b, exp;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = ops[$urandom_range(0, 8)];
      a = $urandom;
      b = $urandom;
      exp = ref_result(op, a, b);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b%0d_accept_ready got %b want 1", i, in_ready); end
      Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
      step();
      Operation = ops[$urandom_range(0, 8)]; SrcA = $urandom; SrcB = $urandom;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b%0d_out_valid got %b want 1", i, out_valid); end
      n_cmp++; if (Result !== exp) begin n_bad++; $display("FAIL b2b%0d_result got %h want %h", i, Result, exp); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b%0d_hold_ready got %b want 0", i, in_ready); end
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b%0d_gap_out_valid got %b want 0", i, out_valid); end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] r;
    logic z;
    int lat;
    Operation = 4'b0111; SrcA = 32'd1; SrcB = 32'd20; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
    n_cmp++; if (Result !== 32'd0) begin n_bad++; $display("FAIL rst_mid_result got %h want 0", Result); end
    n_cmp++; if (Zero !== 1'b1) begin n_bad++; $display("FAIL rst_mid_zero got %b want 1", Zero); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_stale got %b want 0", out_valid); end
    run_op(4'b0010, 32'd1, 32'd1, r, z, lat);
    n_cmp++; if (r !== 32'd2) begin n_bad++; $display("FAIL rst_after_result got %h want 2", r); end
    n_cmp++; if (z !== 1'b0) begin n_bad++; $display("FAIL rst_after_zero got %b want 0", z); end
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL rst_after_latency got %0d want 1", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_iterative.md
# alu_iterative

Multi-cycle integer ALU for the execute stage. It consumes the 4-bit `Operation` code produced by the ALU controller, together with two operands, through a valid/ready handshake. Logic, arithmetic and compare operations complete in one cycle. Shifts execute serially at one bit per cycle, trading shifter area for variable latency. The result is held in an output register until the downstream stage accepts it.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: operand and result width.
- `SHAMT_W`, default `$clog2(DATA_WIDTH)` (derived, not overridden): shift-amount width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: operation request.
- `in_ready`, out, 1: unit can accept a request.
- `Operation`, in, 4: ALU operation code from the controller.
- `SrcA`, in, `DATA_WIDTH`: operand A.
- `SrcB`, in, `DATA_WIDTH`: operand B, or shift amount in `SrcB[SHAMT_W-1:0]`.
- `out_valid`, out, 1: result available.
- `out_ready`, in, 1: downstream accepts the result.
- `Result`, out, `DATA_WIDTH`: registered result.
- `Zero`, out, 1: registered flag, `Result == 0`.

## Operation
- Encodings: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR, 0101 SRL, 0110 SRA, 0111 SLL, 1000 SLT (signed, also used for BLT), 1001 EQ, 1010 NE, 1011 GE (signed).
- 1100–1111 are illegal: Result = 0, Zero = 1, single-cycle path.
- Compare ops (1000–1011): Result = {`DATA_WIDTH-1` zeros, cond}.
- ADD/SUB wrap modulo 2^`DATA_WIDTH`. No carry or overflow output.
- Shift amount is `SrcB[SHAMT_W-1:0]`. Upper bits of `SrcB` are ignored.
- SRA fills with `SrcA[DATA_WIDTH-1]`. SRL and SLL fill with 0.
- `Operation` and both operands are captured on the accepting edge. Later changes are ignored until the next accept.
- FSM states are IDLE, SHIFT and HOLD.
- IDLE: `in_ready` = 1.
  - On `in_valid`, a non-shift op or a shift with amount 0 loads Result and Zero, then goes to HOLD.
  - On `in_valid`, a shift with amount k > 0 loads the working register with `SrcA` and the counter with k, then goes to SHIFT.
- SHIFT: shift the working register 1 bit per cycle and decrement the counter. On the edge where the counter is 1, load Result and Zero from the final shifted value and go to HOLD.
- HOLD: `out_valid` = 1. Result and Zero are stable. When `out_ready` = 1, go to IDLE.
- `in_ready` = (state == IDLE). A request is never accepted in SHIFT or HOLD, even when `out_ready` is high.
- Reset asserted in any state aborts the operation immediately. The in-flight result is discarded and never presented.

## Timing
- Reset values:
  - state IDLE, so `in_ready` = 1
  - `out_valid` = 0
  - `Result` = 0
  - `Zero` = 1
  - counter = 0
  - working register = 0
- Accept in cycle N (`in_valid` and `in_ready` both high at the edge ending N).
  - Non-shift op, illegal op, or shift by 0: `out_valid` = 1 in cycle N+1.
  - Shift by k: `out_valid` = 1 in cycle N+1+k. Worst case is N+`DATA_WIDTH` (k = `DATA_WIDTH`−1).
- Result is consumed at the edge where `out_valid` and `out_ready` are both high. IDLE follows in the next cycle.
- Minimum spacing between accepts is 2 cycles: peak throughput is one operation per 2 cycles.
- `out_valid`, `Result` and `Zero` are register outputs. `in_ready` is decoded from state only, with no combinational path from `out_ready`.
- With `out_ready` held low, HOLD persists indefinitely and Result stays constant.

## Structure
- Shared package `alu_pkg`:
  - `typedef enum logic [3:0] alu_op_e` holding the 12 encodings above.
  - Localparam `ALU_OP_W = 4`.
  - The ALU controller uses the same enum.
- FSM state enum stays local to this module.
- Sub-module `alu_serial_shifter` contains the working register, down-counter, direction/fill control and a done pulse. The top module holds the FSM, the single-cycle datapath and the output register.

## Test plan
- ADD 5 + 7, accepted in cycle 10 → `out_valid` in cycle 11, Result 12, Zero 0.
- SUB 3 − 5 → Result 0xFFFFFFFE in 1 cycle. SUB 9 − 9 → Result 0, Zero 1.
- SRA 0x80000000 by 4, accepted in cycle N → `out_valid` first in N+5, Result 0xF8000000. SLL 1 by 0 → Result 1 at N+1. SRL 0xFFFFFFFF with `SrcB` = 0x21 (amount 1) → Result 0x7FFFFFFF at N+2.
- Compares: SLT 0xFFFFFFFF vs 1 → 1. GE 0xFFFFFFFF vs 1 → 0. EQ 4 vs 4 → 1. NE 4 vs 4 → 0, Zero 1. Opcode 1111 → Result 0, Zero 1.
- Backpressure: XOR result held with `out_ready` low for 3 cycles → Result stable, `in_ready` 0, a concurrent `in_valid` is ignored. `out_ready` high → IDLE next cycle, the next request is accepted.
- Reset mid-shift (SLL by 20, `rst_n` low at cycle N+6) → `out_valid` 0, Result 0, Zero 1, `in_ready` 1 asynchronously. After release, ADD 1 + 1 → Result 2 at latency 1.
